// File: rtl/float_to_int_if.sv
// Handshake bundle for the float_to_int converter.
// The master side is the producer/consumer; the slave side is the converter.
interface float_to_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/float_to_int.sv
// 16-bit float to int16 converter, round toward zero, one shift per cycle.
// Define FTOI_SATURATE_EN to saturate non-NaN overflow instead of returning zero.
module float_to_int #(
    parameter int EXP_BIAS  = 127,
    parameter int FRAC_BITS = 7
) (
    input logic           clk,
    input logic           reset,
    float_to_int_if.slave bus
);
    localparam int W     = 16;
    localparam int EXP_W = W - 1 - FRAC_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0] r_sh;
    logic [3:0]   r_cnt;
    logic         r_dir;
    logic         r_sign;
    logic [W-1:0] r_data;
    logic         r_ovf;

    logic                 w_sign;
    logic [EXP_W-1:0]     w_exp;
    logic [FRAC_BITS-1:0] w_trail;
    logic signed [31:0]   w_e;
    logic                 w_nan;
    logic                 w_over;
    logic                 w_zero;
    logic                 w_norm;
    logic [3:0]           w_cnt;
    logic [W-1:0]         w_sat;

    assign w_sign  = bus.in_data[W-1];
    assign w_exp   = bus.in_data[W-2:FRAC_BITS];
    assign w_trail = bus.in_data[FRAC_BITS-1:0];
    assign w_e     = $signed(32'(w_exp)) - EXP_BIAS;

    // Mutually exclusive classes; only -2^15 survives at the top exponent.
    assign w_nan  = (&w_exp) && (|w_trail);
    assign w_over = !w_nan && ((w_e > W - 1) ||
                    ((w_e == W - 1) && !(w_sign && (w_trail == '0))));
    assign w_zero = !w_nan && !w_over && ((w_exp == '0) || (w_e < 0));
    assign w_norm = !w_nan && !w_over && !w_zero;

    assign w_cnt = (w_e >= FRAC_BITS) ? 4'(w_e - FRAC_BITS)
                                      : 4'(FRAC_BITS - w_e);

`ifdef FTOI_SATURATE_EN
    assign w_sat = w_sign ? 16'h8000 : 16'h7FFF;
`else
    assign w_sat = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = w_norm ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == '0)  w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.busy      = (r_state != S_IDLE);
        bus.out_data  = r_data;
        bus.out_ovf   = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_sign <= 1'b0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= w_sign;
                        r_sh   <= W'({1'b1, w_trail});
                        r_cnt  <= w_cnt;
                        r_dir  <= (w_e >= FRAC_BITS);
                        unique case (1'b1)
                            w_nan:  begin r_data <= '0;    r_ovf <= 1'b1; end
                            w_over: begin r_data <= w_sat; r_ovf <= 1'b1; end
                            w_zero: begin r_data <= '0;    r_ovf <= 1'b0; end
                            w_norm: ;
                        endcase
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_sh  <= r_dir ? (r_sh << 1) : (r_sh >> 1);
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_FIX: begin
                    r_data <= r_sign ? (~r_sh + 16'd1) : r_sh;
                    r_ovf  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed cases, reset abort,
// backpressure and random operands against a value-range reference model.
module tb_float_to_int;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    float_to_int_if bus ();

    float_to_int dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] sat_val(input logic s);
`ifdef FTOI_SATURATE_EN
        return s ? 16'h8000 : 16'h7FFF;
`else
        return 16'h0000;
`endif
    endfunction

    // Reference: real value range check on an exact integer magnitude.
    // Latency counts edges from the accept edge inclusive.
    function automatic void model(input logic [15:0] d, output logic [15:0] r,
                                  output logic ovf, output int lat);
        int     ex;
        int     e;
        longint m;
        longint v;
        ex  = int'(d[14:7]);
        e   = ex - 127;
        m   = 128 + longint'(d[6:0]);
        lat = 1;
        r   = 16'h0000;
        ovf = 1'b0;
        if (ex == 255) begin
            ovf = 1'b1;
            if (d[6:0] == 7'd0) r = sat_val(d[15]);
        end else if (ex == 0 || e < 0) begin
            r = 16'h0000;
        end else if (e > 30) begin
            r   = sat_val(d[15]);
            ovf = 1'b1;
        end else begin
            v = (e >= 7) ? (m << (e - 7)) : (m >> (7 - e));
            if (d[15]) v = -v;
            if (v > 32767 || v < -32768) begin
                r   = sat_val(d[15]);
                ovf = 1'b1;
            end else begin
                r   = v[15:0];
                lat = ((e >= 7) ? e - 7 : 7 - e) + 3;
            end
        end
    endfunction

    task automatic do_op(input logic [15:0] d, input int stall);
        logic [15:0] er;
        logic        eo;
        int          el;
        int          lat;
        model(d, er, eo, el);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_data = 16'($urandom);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("latency", 32'(lat), 32'(el));
        chk("out_data", 32'(bus.out_data), 32'(er));
        chk("out_ovf", 32'(bus.out_ovf), 32'(eo));
        chk("in_ready_done", 32'(bus.in_ready), 0);
        repeat (stall) begin
            @(negedge clk);
            bus.in_data = 16'($urandom);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_data", 32'(bus.out_data), 32'(er));
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_valid", 32'(bus.out_valid), 0);
        chk("release_busy", 32'(bus.busy), 0);
        chk("release_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic        seen;
        logic [15:0] d;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_ovf", 32'(bus.out_ovf), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        reset = 1'b0;

        do_op(16'h4320, 0);
        do_op(16'hC320, 0);
        do_op(16'h3F80, 0);
        do_op(16'h3F00, 0);
        do_op(16'hBFC0, 0);
        do_op(16'hC700, 0);
        do_op(16'h4700, 0);
        do_op(16'hC701, 0);
        do_op(16'h46FF, 0);
        do_op(16'h7FC1, 0);
        do_op(16'h7F80, 0);
        do_op(16'hFF80, 0);
        do_op(16'h0041, 0);
        do_op(16'h4320, 5);

        @(negedge clk);
        bus.in_data  = 16'h3F80;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_idle", 32'(bus.busy), 0);
        chk("abort_ready", 32'(bus.in_ready), 1);
        chk("abort_data", 32'(bus.out_data), 0);
        chk("abort_ovf", 32'(bus.out_ovf), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_out", 32'(seen), 0);
        do_op(16'h4320, 0);

        for (int i = 0; i < 40; i++) begin
            d[15]   = 1'($urandom);
            d[6:0]  = 7'($urandom);
            d[14:7] = ($urandom_range(0, 9) < 8) ?
                      8'($urandom_range(120, 145)) : 8'($urandom_range(0, 255));
            do_op(d, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
